sccb_target: RTL and testbench
==============================

Name: sccb_target

Overview:
- SCCB/I2C target (responder) for the OV7670 camera control link: the far end of the on-chip SCCB master.
- Decodes START, STOP and repeated START from open-drain SCL/SDA.
- Matches a 7-bit device address, latches a register sub-address, and presents writes as single-cycle strobes on a parallel register port.
- Sources read data from that port. Used as a camera register model in simulation and as a loopback target on the board.

Parameters:
DEV_ADDR, 7'h21, 7-bit device address (write byte 0x42, read byte 0x43)
FILTER_LEN, 3, consecutive identical clk samples required before a filtered SCL/SDA level changes (1..15)

Ports:
clk  input  1  system clock, 100 MHz nominal
reset_n  input  1  asynchronous active-low reset
scl  input  1  SCCB clock from the master; the target never stretches it
sda  inout  1  SCCB data, open-drain; driven only as 0 or Z
wr_valid  output  1  one-clk strobe: register write
wr_addr  output  8  register address for wr_valid
wr_data  output  8  register data for wr_valid
rd_addr  output  8  current register pointer
rd_data  input  8  combinational register contents at rd_addr
busy  output  1  high from an address-matched START until STOP
nack_seen  output  1  sticky: master NACKed a read byte; cleared by the next START

Behaviour:
- Reset (async assert, sync release): state IDLE, SDA released (Z), wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, nack_seen=0, filters preset to 1.
- Input path: 2-FF synchronizer on SCL and SDA, then a FILTER_LEN glitch filter. All edges below refer to filtered signals.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are valid in every state, including mid-byte.
- START (or repeated START) -> ADDR, bit counter cleared, nack_seen cleared.
- STOP -> IDLE, SDA released, busy=0.
- Data bits: sampled MSB-first on SCL rising edge. The target changes SDA only on the clk after an SCL falling edge.
- States:
  - IDLE: SDA=Z; wait for START.
  - ADDR: shift 8 bits. If [7:1]==DEV_ADDR -> ADDR_ACK, busy=1, latch R/W; otherwise -> IGNORE.
  - ADDR_ACK: drive SDA=0 for one SCL period. Write -> SUB. Read -> RDATA, loading the shifter from rd_data at the falling edge that ends the ACK.
  - SUB: shift 8 bits into the pointer (rd_addr) -> SUB_ACK (drive 0) -> WDATA.
  - WDATA: shift 8 bits. One clk after the SCL rising edge sampling bit 0: wr_valid=1 for exactly 1 clk, wr_addr=pointer, wr_data=byte. Then -> WDATA_ACK (drive 0) -> WDATA.
  - RDATA: drive shifter bits (0 -> 0, 1 -> Z) -> MACK, SDA released.
  - MACK: sample SDA on SCL rising. 0 (ACK) -> reload from rd_data, -> RDATA. 1 (NACK) -> nack_seen=1, -> IGNORE.
  - IGNORE: SDA=Z; wait for START/STOP.
- Pointer is 8-bit and wraps 0xFF -> 0x00. It persists across transactions, so a 2-phase SCCB read (write sub-address, STOP, read) returns the addressed register.
- A START arriving while SDA is driven low releases SDA on the same clk.
- Async reset mid-transaction forces the reset values immediately. The first transaction after release must start with a fresh START.

Optional Feature:
- SCCB_AUTOINC_EN defined: pointer increments (wrapping) after each WDATA byte's wr_valid and after each master-ACKed read byte. Multi-byte bursts are supported.
- Not defined: pointer changes only in SUB. Successive data bytes write, or read, the same register.

Test Plan:
- Write 0x42, 0x12, 0x80, STOP -> three ACKs; exactly one wr_valid with wr_addr=0x12, wr_data=0x80; busy falls at STOP.
- Address 0x60 (7'h30) -> no ACK; SDA never driven; no wr_valid; busy stays 0.
- Write 0x42, 0x0A, STOP, then 0x43 with rd_data=0x76 for rd_addr=0x0A; master NACKs -> bus reads 0x76; nack_seen=1; SDA released before STOP.
- SCCB_AUTOINC_EN: write 0x42, 0xFE, 0x11, 0x22, 0x33 -> wr_valid at addr 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33. Without the macro, all three land at 0xFE.
- Repeated START after 4 bits of a data byte, then 0x43 -> partial byte discarded, no wr_valid, read proceeds from the pointer.
- 1-clk glitches on SCL with FILTER_LEN=3, plus reset_n pulsed low mid-RDATA -> no spurious bits; SDA released combinationally-asynchronously on reset; state IDLE.

Source files
------------

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C target (responder) for the OV7670 control link.
// Decodes START/STOP/repeated START from the open-drain bus, matches a 7-bit
// device address, latches a register sub-address and exposes a parallel
// register port (write strobe out, combinational read data in).
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   scl        bus clock from the master (never stretched)
//   sda        bus data, open-drain (driven 0 or Z only)
//   wr_valid   one-clk register write strobe
//   wr_addr    register address for wr_valid
//   wr_data    register data for wr_valid
//   rd_addr    current register pointer
//   rd_data    register contents at rd_addr (combinational from the user)
//   busy       high from an address-matched START until STOP
//   nack_seen  sticky: master NACKed a read byte; cleared by the next START
//
// Build option: define SCCB_AUTOINC_EN to auto-increment the pointer after
// every written byte and every master-ACKed read byte.

module sccb_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h21,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       nack_seen
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;

  // Open-drain pad: only ever pull low
  logic sda_oe_q;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Two-flop synchronizers, preset to the idle-bus level
  logic [1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {sda, scl};
      sync_q <= meta_q;
    end
  end

  // Glitch filters: level changes after FILTER_LEN consecutive differing samples
  logic [CNT_W-1:0] scl_cnt_q, sda_cnt_q;
  logic             scl_f_q, sda_f_q, scl_d_q, sda_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_cnt_q <= '0;
      scl_f_q   <= 1'b1;
    end else if (sync_q[0] == scl_f_q) begin
      scl_cnt_q <= '0;
    end else if (scl_cnt_q == FILT_MAX) begin
      scl_cnt_q <= '0;
      scl_f_q   <= sync_q[0];
    end else begin
      scl_cnt_q <= scl_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sda_cnt_q <= '0;
      sda_f_q   <= 1'b1;
    end else if (sync_q[1] == sda_f_q) begin
      sda_cnt_q <= '0;
    end else if (sda_cnt_q == FILT_MAX) begin
      sda_cnt_q <= '0;
      sda_f_q   <= sync_q[1];
    end else begin
      sda_cnt_q <= sda_cnt_q + CNT_W'(1);
    end
  end

  // Previous filtered levels for edge/condition detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
    end else begin
      scl_d_q <= scl_f_q;
      sda_d_q <= sda_f_q;
    end
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c;
  assign scl_rise_c = scl_f_q & ~scl_d_q;
  assign scl_fall_c = ~scl_f_q & scl_d_q;
  assign start_c    = scl_f_q & scl_d_q & sda_d_q & ~sda_f_q;
  assign stop_c     = scl_f_q & scl_d_q & ~sda_d_q & sda_f_q;

  // Protocol state
  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             sda_oe_d;
  logic             wr_valid_d;
  logic [7:0]       wr_addr_d, wr_data_d;
  logic             busy_d, nack_d;
  logic [7:0]       shift_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      nack_seen <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      wr_valid  <= wr_valid_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
      nack_seen <= nack_d;
    end
  end

  assign rd_addr = ptr_q;

  // Next-state and output logic. ACK states drive SDA on the first SCL fall
  // and release it on the second, using sda_oe_q itself as the phase flag.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    busy_d     = busy;
    nack_d     = nack_seen;
    shift_in   = {shreg_q[6:0], sda_f_q};

    if (start_c) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      nack_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise_c) begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) begin
              bit_cnt_d = '0;
              if (shift_in[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              state_d   = RDATA;
              shreg_d   = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = '0;
            end else begin
              state_d   = SUB;
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
            end
          end
        end
        SUB: begin
          if (scl_rise_c) begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) begin
              bit_cnt_d = '0;
              ptr_d     = shift_in;
              state_d   = SUB_ACK;
            end
          end
        end
        SUB_ACK, WDATA_ACK: begin
          if (scl_fall_c) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = WDATA;
            end
          end
        end
        WDATA: begin
          if (scl_rise_c) begin
            shreg_d   = shift_in;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(7)) begin
              bit_cnt_d  = '0;
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = shift_in;
`ifdef SCCB_AUTOINC_EN
              ptr_d      = ptr_q + 8'd1;
`endif
              state_d    = WDATA_ACK;
            end
          end
        end
        RDATA: begin
          // bit_cnt counts SCL rises; the fall after the 8th hands SDA back
          if (scl_rise_c) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (scl_fall_c) begin
            if (bit_cnt_q == BIT_W'(8)) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = MACK;
            end else begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end
          end
        end
        MACK: begin
          // bit_cnt==1 marks a master ACK awaiting the reload fall
          if (scl_rise_c) begin
            if (!sda_f_q) begin
              bit_cnt_d = BIT_W'(1);
`ifdef SCCB_AUTOINC_EN
              ptr_d     = ptr_q + 8'd1;
`endif
            end else begin
              nack_d  = 1'b1;
              state_d = IGNORE;
            end
          end else if (scl_fall_c && bit_cnt_q == BIT_W'(1)) begin
            state_d   = RDATA;
            shreg_d   = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = '0;
          end
        end
        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target acting as a bus master with
// a pulled-up open-drain SDA. Register file model: rd_data = rd_addr ^ 8'h7C.

module tb_sccb_target;

  localparam int Q = 200;

  logic       clk;
  logic       reset_n;
  logic       scl_m;
  logic       m_low;
  wire        sda;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       nack_seen;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rd_data = rd_addr ^ 8'h7C;

  sccb_target #(.DEV_ADDR(7'h21), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl       (scl_m),
    .sda       (sda),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .nack_seen (nack_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int fail_cnt = 0;

  // Bus monitors: write log, unexpected target drive, busy cycles
  int         wr_cnt   = 0;
  int         drv_cnt  = 0;
  int         busy_cnt = 0;
  logic [7:0] log_addr [64];
  logic [7:0] log_data [64];

  always @(posedge clk) begin
    if (wr_valid) begin
      log_addr[wr_cnt[5:0]] <= wr_addr;
      log_data[wr_cnt[5:0]] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (sda === 1'b0 && !m_low) drv_cnt <= drv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_bit(input logic b, output logic r);
    m_low = ~b; #Q;
    scl_m = 1'b1; #Q;
    r = sda; #Q;
    scl_m = 1'b0; #Q;
  endtask

  // Same bit with 1-clk glitches on SCL (both phases) and SDA (high phase)
  task automatic gl_bit(input logic b);
    m_low = ~b; #100;
    scl_m = 1'b1; #10; scl_m = 1'b0; #90;
    scl_m = 1'b1; #100;
    scl_m = 1'b0; #10; scl_m = 1'b1; #100;
    m_low = b; #10; m_low = ~b; #180;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    m_low = 1'b1; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    m_low = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, r);
      d = {d[6:0], r};
    end
    bus_bit(~mack, r);
  endtask

  logic       ack;
  logic       r;
  logic [7:0] d;
  int         wr0, drv0, busy0;
  logic [7:0] exp_ptr;

  initial begin
    reset_n = 1'b0;
    scl_m   = 1'b1;
    m_low   = 1'b0;
    #40;
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_rd_addr", rd_addr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nack", nack_seen, 1'b0);
    chk("rst_sda", sda, 1'b1);
    reset_n = 1'b1;
    #100;

    // Single register write
    wr0 = wr_cnt;
    bus_start();
    wr_byte(8'h42, ack); chk("w1_ack_addr", ack, 1'b1);
    wr_byte(8'h12, ack); chk("w1_ack_sub", ack, 1'b1);
    wr_byte(8'h80, ack); chk("w1_ack_data", ack, 1'b1);
    chk("w1_busy_before_stop", busy, 1'b1);
    bus_stop();
    #Q;
    chk("w1_busy_after_stop", busy, 1'b0);
    chk("w1_wr_count", wr_cnt - wr0, 1);
    chk("w1_wr_addr", log_addr[6'(wr0)], 8'h12);
    chk("w1_wr_data", log_data[6'(wr0)], 8'h80);
`ifdef SCCB_AUTOINC_EN
    chk("w1_ptr", rd_addr, 8'h13);
`else
    chk("w1_ptr", rd_addr, 8'h12);
`endif

    // Foreign device address: target stays silent
    wr0 = wr_cnt; drv0 = drv_cnt; busy0 = busy_cnt;
    bus_start();
    wr_byte(8'h60, ack); chk("foreign_ack_addr", ack, 1'b0);
    wr_byte(8'h55, ack); chk("foreign_ack_data", ack, 1'b0);
    bus_stop();
    #Q;
    chk("foreign_no_drive", drv_cnt - drv0, 0);
    chk("foreign_no_busy", busy_cnt - busy0, 0);
    chk("foreign_no_write", wr_cnt - wr0, 0);

    // Two-phase read: set pointer, STOP, then read with master NACK
    bus_start();
    wr_byte(8'h42, ack); chk("r2_ack_addr", ack, 1'b1);
    wr_byte(8'h0A, ack); chk("r2_ack_sub", ack, 1'b1);
    bus_stop();
    #Q;
    chk("r2_ptr", rd_addr, 8'h0A);
    bus_start();
    wr_byte(8'h43, ack); chk("r2_ack_rd", ack, 1'b1);
    rd_byte(1'b0, d);
    chk("r2_data", d, 8'h76);
    chk("r2_nack_seen", nack_seen, 1'b1);
    chk("r2_sda_released", sda, 1'b1);
    bus_stop();
    #Q;
    chk("r2_nack_sticky", nack_seen, 1'b1);
    chk("r2_busy_after_stop", busy, 1'b0);
    chk("r2_ptr_after", rd_addr, 8'h0A);

    // Three-byte write burst starting at 0xFE
    wr0 = wr_cnt;
    bus_start();
    wr_byte(8'h42, ack); chk("b3_ack_addr", ack, 1'b1);
    wr_byte(8'hFE, ack); chk("b3_ack_sub", ack, 1'b1);
    wr_byte(8'h11, ack); chk("b3_ack_d0", ack, 1'b1);
    wr_byte(8'h22, ack); chk("b3_ack_d1", ack, 1'b1);
    wr_byte(8'h33, ack); chk("b3_ack_d2", ack, 1'b1);
    bus_stop();
    #Q;
    chk("b3_wr_count", wr_cnt - wr0, 3);
    chk("b3_data0", log_data[6'(wr0)], 8'h11);
    chk("b3_data1", log_data[6'(wr0 + 1)], 8'h22);
    chk("b3_data2", log_data[6'(wr0 + 2)], 8'h33);
`ifdef SCCB_AUTOINC_EN
    chk("b3_addr0", log_addr[6'(wr0)], 8'hFE);
    chk("b3_addr1", log_addr[6'(wr0 + 1)], 8'hFF);
    chk("b3_addr2", log_addr[6'(wr0 + 2)], 8'h00);
    chk("b3_ptr", rd_addr, 8'h01);
`else
    chk("b3_addr0", log_addr[6'(wr0)], 8'hFE);
    chk("b3_addr1", log_addr[6'(wr0 + 1)], 8'hFE);
    chk("b3_addr2", log_addr[6'(wr0 + 2)], 8'hFE);
    chk("b3_ptr", rd_addr, 8'hFE);
`endif

    // Repeated START after half a data byte, then a two-byte read
    wr0 = wr_cnt;
    bus_start();
    chk("rs_nack_cleared", nack_seen, 1'b0);
    wr_byte(8'h42, ack); chk("rs_ack_addr", ack, 1'b1);
    wr_byte(8'h20, ack); chk("rs_ack_sub", ack, 1'b1);
    bus_bit(1'b1, r); bus_bit(1'b0, r); bus_bit(1'b1, r); bus_bit(1'b0, r);
    bus_start();
    wr_byte(8'h43, ack); chk("rs_ack_rd", ack, 1'b1);
    chk("rs_busy", busy, 1'b1);
    rd_byte(1'b1, d);
    chk("rs_data0", d, 8'h5C);
    chk("rs_nack_mid", nack_seen, 1'b0);
    rd_byte(1'b0, d);
`ifdef SCCB_AUTOINC_EN
    chk("rs_data1", d, 8'h5D);
`else
    chk("rs_data1", d, 8'h5C);
`endif
    chk("rs_nack_end", nack_seen, 1'b1);
    bus_stop();
    #Q;
    chk("rs_no_write", wr_cnt - wr0, 0);

    // Write with 1-clk glitches on SCL and SDA
    wr0 = wr_cnt;
    bus_start();
    wr_byte(8'h42, ack); chk("gl_ack_addr", ack, 1'b1);
    wr_byte(8'h33, ack); chk("gl_ack_sub", ack, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      d = 8'h5A;
      gl_bit(d[i]);
    end
    bus_bit(1'b1, r); chk("gl_ack_data", r, 1'b0);
    bus_stop();
    #Q;
    chk("gl_wr_count", wr_cnt - wr0, 1);
    chk("gl_wr_addr", log_addr[6'(wr0)], 8'h33);
    chk("gl_wr_data", log_data[6'(wr0)], 8'h5A);
`ifdef SCCB_AUTOINC_EN
    exp_ptr = 8'h34;
`else
    exp_ptr = 8'h33;
`endif
    chk("gl_ptr", rd_addr, exp_ptr);

    // Reset pulse while the target drives a read bit low
    bus_start();
    wr_byte(8'h43, ack); chk("rr_ack_rd", ack, 1'b1);
    chk("rr_bit7_driven", sda, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rr_sda_released", sda, 1'b1);
    chk("rr_busy", busy, 1'b0);
    chk("rr_rd_addr", rd_addr, 8'h00);
    chk("rr_wr_addr", wr_addr, 8'h00);
    chk("rr_wr_data", wr_data, 8'h00);
    chk("rr_wr_valid", wr_valid, 1'b0);
    #29;
    reset_n = 1'b1;
    #Q;
    drv0 = drv_cnt;
    for (int i = 0; i < 4; i++) bus_bit(1'b1, r);
    bus_stop();
    #Q;
    chk("rr_idle_no_drive", drv_cnt - drv0, 0);

    // Fresh transaction after reset
    wr0 = wr_cnt;
    bus_start();
    wr_byte(8'h42, ack); chk("pr_ack_addr", ack, 1'b1);
    wr_byte(8'h05, ack); chk("pr_ack_sub", ack, 1'b1);
    wr_byte(8'h99, ack); chk("pr_ack_data", ack, 1'b1);
    bus_stop();
    #Q;
    chk("pr_wr_count", wr_cnt - wr0, 1);
    chk("pr_wr_addr", log_addr[6'(wr0)], 8'h05);
    chk("pr_wr_data", log_data[6'(wr0)], 8'h99);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
